multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath (R-type, addi, lw, sw, beq, j), the FSM counterpart of the
//  single-cycle opcode decoder. It sequences shared ALU/memory/register file over FETCH..WB, handshakes
//  with a variable-latency memory, counts retired instructions, flags illegal opcodes and memory timeouts.
// PARAMETERS
//  MEM_TIMEOUT  8   consecutive no-ack cycles in FETCH/MEM before entering ERR; 0 disables timeout
//  CNT_W        16  width of retired-instruction counter instr_cnt_o
// PORTS
//  clk_i         in   1      clock, rising edge
//  rst_i         in   1      reset, asynchronous, active-high
//  start_i       in   1      leave IDLE and begin fetching
//  halt_i        in   1      stop at next instruction boundary, return to IDLE
//  op_i          in   6      opcode from memory read data [31:26], valid with mem_ack_i in FETCH
//  mem_ack_i     in   1      memory completes current request this cycle
//  mem_req_o     out  1      memory request (FETCH, MEM)
//  MemRead_o / MemWrite_o / IorD_o / IRWrite_o  out 1 each   memory-side controls
//  PCWrite_o / PCWriteCond_o  out 1 each; PCSource_o out 2   PC update (00 ALU, 01 ALUOut, 10 jump)
//  ALUSrcA_o out 1; ALUSrcB_o out 2 (00 B, 01 const 4, 10 signext, 11 signext<<2); ALUOp_o out 2
//  RegWrite_o / RegDst_o / MemtoReg_o  out 1 each            register-file writeback controls
//  state_o       out  3      current state encoding (debug)
//  illegal_o     out  1      one-cycle pulse: unknown opcode in DECODE
//  err_o         out  1      sticky memory-timeout error
//  instr_cnt_o   out  CNT_W  retired legal instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 ERR=7. Outputs combinational from state, op_q, mem_ack_i;
//  every control not listed for a state is 0. Reset: state IDLE, op_q=0, wait_cnt=0, instr_cnt=0, all outputs 0.
//  IDLE: start_i -> FETCH.
//  FETCH: mem_req,MemRead,IorD=0,ALUSrcA=0,ALUSrcB=01,ALUOp=00. On mem_ack_i: IRWrite=1,PCWrite=1,
//    PCSource=00, op_q<=op_i -> DECODE; else stay.
//  DECODE: ALUSrcA=0,ALUSrcB=11,ALUOp=00 (branch target into ALUOut). Legal op_q -> EXEC;
//    unknown -> illegal_o=1, not counted, -> FETCH (or IDLE if halt_i).
//  EXEC: R: ALUSrcA=1,ALUSrcB=00,ALUOp=10 -> WB. addi/lw/sw: ALUSrcA=1,ALUSrcB=10,ALUOp=00;
//    addi -> WB, lw/sw -> MEM. beq: ALUSrcA=1,ALUSrcB=00,ALUOp=01,PCWriteCond=1,PCSource=01 -> FETCH.
//    j: PCWrite=1,PCSource=10 -> FETCH.
//  MEM: mem_req,IorD=1; MemRead (lw) or MemWrite (sw), held until mem_ack_i; then lw -> WB, sw -> FETCH.
//  WB: RegWrite=1; R: RegDst=1,MemtoReg=0; addi: RegDst=0,MemtoReg=0; lw: RegDst=0,MemtoReg=1 -> FETCH.
//  Boundary: every transition into FETCH from DECODE/EXEC/MEM/WB goes to IDLE instead if halt_i=1.
//  Retire: instr_cnt++ on the clock that leaves EXEC(beq,j), MEM(sw) or WB toward FETCH/IDLE; wraps max->0.
//  Timeout: wait_cnt cleared on entering FETCH/MEM and on ack; increments each FETCH/MEM cycle with ack low;
//    when wait_cnt==MEM_TIMEOUT-1 and ack low (MEM_TIMEOUT consecutive misses) -> ERR next clock.
//    Ack on the MEM_TIMEOUT-th cycle is accepted. Ack and timeout same cycle: ack wins.
//  ERR: err_o=1, all controls 0, start_i/halt_i ignored; exit only by reset.
//  Latency (ack same cycle as req): R/addi 4 cycles, lw 5, sw 4, beq/j 3; each memory wait adds 1.
//  Reset mid-instruction: immediate return to IDLE, in-flight mem_req/RegWrite deasserted asynchronously.
// TESTING
//  R-type add, immediate ack: start_i=1 -> states 1,2,3,5,1; RegWrite=1,RegDst=1 in WB; instr_cnt 0->1.
//  lw, ack 2 cycles late in FETCH and MEM -> 9 cycles FETCH..WB; MemtoReg=1 in WB; IorD=1 only in MEM.
//  beq then j: PCWriteCond=1,PCSource=01 in beq EXEC; PCWrite=1,PCSource=10 in j EXEC; instr_cnt +2.
//  MEM_TIMEOUT=8, mem_ack_i stuck 0 in FETCH -> ERR after 8 FETCH cycles, err_o=1; ack on cycle 8 -> DECODE.
//  op_i=6'b111111 -> illegal_o pulses 1 cycle in DECODE, back to FETCH, instr_cnt unchanged.
//  halt_i=1 during sw MEM wait -> sw completes, IDLE next; rst_i mid-MEM -> IDLE, mem_req_o=0 same cycle.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Bundle of control/handshake signals between the multi-cycle sequencer and
// its datapath + memory.
//   master : sequencer side (drives controls, status and counter)
//   slave  : datapath/memory side (drives start/halt, opcode, memory ack)
// Signal names keep the datapath's historical names so the control word
// lines up with the schematic.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic             halt_i;
  logic [5:0]       op_i;
  logic             mem_ack_i;
  logic             mem_req_o;
  logic             MemRead_o;
  logic             MemWrite_o;
  logic             IorD_o;
  logic             IRWrite_o;
  logic             PCWrite_o;
  logic             PCWriteCond_o;
  logic [1:0]       PCSource_o;
  logic             ALUSrcA_o;
  logic [1:0]       ALUSrcB_o;
  logic [1:0]       ALUOp_o;
  logic             RegWrite_o;
  logic             RegDst_o;
  logic             MemtoReg_o;
  logic [2:0]       state_o;
  logic             illegal_o;
  logic             err_o;
  logic [CNT_W-1:0] instr_cnt_o;

  modport master (
    input  start_i, halt_i, op_i, mem_ack_i,
    output mem_req_o, MemRead_o, MemWrite_o, IorD_o, IRWrite_o,
           PCWrite_o, PCWriteCond_o, PCSource_o, ALUSrcA_o, ALUSrcB_o,
           ALUOp_o, RegWrite_o, RegDst_o, MemtoReg_o, state_o, illegal_o,
           err_o, instr_cnt_o
  );

  modport slave (
    output start_i, halt_i, op_i, mem_ack_i,
    input  mem_req_o, MemRead_o, MemWrite_o, IorD_o, IRWrite_o,
           PCWrite_o, PCWriteCond_o, PCSource_o, ALUSrcA_o, ALUSrcB_o,
           ALUOp_o, RegWrite_o, RegDst_o, MemtoReg_o, state_o, illegal_o,
           err_o, instr_cnt_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer (R-type, addi, lw, sw, beq, j).
// Walks FETCH/DECODE/EXEC/MEM/WB over a shared ALU, memory and register
// file, waits on a variable-latency memory, counts retired instructions,
// flags unknown opcodes and traps into a sticky ERR state on memory timeout.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    multicycle_ctrl_if.master: start/halt/op/ack in, controls,
//          state, illegal pulse, error flag and retired count out
// All controls are decoded combinationally from state, latched opcode and
// mem_ack_i, so an asynchronous reset drops them in the same cycle.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_ERR    = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // Counter just wide enough to hold MEM_TIMEOUT-1; with the timeout
  // disabled it free-runs and is ignored.
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t           state, state_d;
  logic [5:0]       op_q;
  logic [WW-1:0]    wait_cnt, wait_cnt_d;
  logic [CNT_W-1:0] instr_cnt;
  logic             retire, legal, timeout;
  state_t           boundary;

  always_comb begin
    legal    = op_q inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
    timeout  = (MEM_TIMEOUT != 0) && !bus.mem_ack_i &&
               (wait_cnt == WW'(MEM_TIMEOUT - 1));
    // Every return to FETCH is an instruction boundary where halt applies.
    boundary = bus.halt_i ? S_IDLE : S_FETCH;

    state_d           = state;
    retire            = 1'b0;
    bus.mem_req_o     = 1'b0;
    bus.MemRead_o     = 1'b0;
    bus.MemWrite_o    = 1'b0;
    bus.IorD_o        = 1'b0;
    bus.IRWrite_o     = 1'b0;
    bus.PCWrite_o     = 1'b0;
    bus.PCWriteCond_o = 1'b0;
    bus.PCSource_o    = 2'b00;
    bus.ALUSrcA_o     = 1'b0;
    bus.ALUSrcB_o     = 2'b00;
    bus.ALUOp_o       = 2'b00;
    bus.RegWrite_o    = 1'b0;
    bus.RegDst_o      = 1'b0;
    bus.MemtoReg_o    = 1'b0;
    bus.illegal_o     = 1'b0;
    bus.err_o         = 1'b0;

    case (state)
      S_IDLE: if (bus.start_i) state_d = S_FETCH;
      S_FETCH: begin
        // ALU computes PC+4 while the instruction is read.
        bus.mem_req_o = 1'b1;
        bus.MemRead_o = 1'b1;
        bus.ALUSrcB_o = 2'b01;
        if (bus.mem_ack_i) begin
          bus.IRWrite_o = 1'b1;
          bus.PCWrite_o = 1'b1;
          state_d       = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        bus.ALUSrcB_o = 2'b11;
        if (legal) state_d = S_EXEC;
        else begin
          bus.illegal_o = 1'b1;
          state_d       = boundary;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_R: begin
            bus.ALUSrcA_o = 1'b1;
            bus.ALUOp_o   = 2'b10;
            state_d       = S_WB;
          end
          OP_ADDI, OP_LW, OP_SW: begin
            bus.ALUSrcA_o = 1'b1;
            bus.ALUSrcB_o = 2'b10;
            state_d       = (op_q == OP_ADDI) ? S_WB : S_MEM;
          end
          OP_BEQ: begin
            bus.ALUSrcA_o     = 1'b1;
            bus.ALUOp_o       = 2'b01;
            bus.PCWriteCond_o = 1'b1;
            bus.PCSource_o    = 2'b01;
            retire            = 1'b1;
            state_d           = boundary;
          end
          OP_J: begin
            bus.PCWrite_o  = 1'b1;
            bus.PCSource_o = 2'b10;
            retire         = 1'b1;
            state_d        = boundary;
          end
          default: state_d = boundary;  // unreachable: DECODE filters
        endcase
      end
      S_MEM: begin
        bus.mem_req_o  = 1'b1;
        bus.IorD_o     = 1'b1;
        bus.MemWrite_o = (op_q == OP_SW);
        bus.MemRead_o  = (op_q != OP_SW);
        if (bus.mem_ack_i) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_d = boundary;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        bus.RegWrite_o = 1'b1;
        bus.RegDst_o   = (op_q == OP_R);
        bus.MemtoReg_o = (op_q == OP_LW);
        retire         = 1'b1;
        state_d        = boundary;
      end
      S_ERR: bus.err_o = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // Count only consecutive misses within one FETCH/MEM visit; entering,
    // acking or leaving all restart it.
    wait_cnt_d = '0;
    if ((state == S_FETCH || state == S_MEM) && !bus.mem_ack_i &&
        state_d == state)
      wait_cnt_d = wait_cnt + 1'b1;

    bus.state_o     = state;
    bus.instr_cnt_o = instr_cnt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      op_q      <= '0;
      wait_cnt  <= '0;
      instr_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
      if (state == S_FETCH && bus.mem_ack_i) op_q <= bus.op_i;
      if (retire) instr_cnt <= instr_cnt + 1'b1;
    end
  end
endmodule
